// File: rtl/mem_arbiter.sv
// Single-access sequencer sharing a 128-bit memory bank between NUM_RT ray-tracer cores and the MC.
// Define MEM_ARB_MC_PRIO_EN to give the MC strict priority; otherwise it is one slot of the round-robin ring.
module mem_arbiter #(
  parameter int NUM_RT  = 4,
  parameter int ADDR_W  = 14,
  parameter int MEM_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_RT-1:0]   req_RT,
  input  logic [NUM_RT-1:0]   we_RT,
  input  logic [31:0]         addr_RT [NUM_RT],
  input  logic [127:0]        data_RT_in [NUM_RT],
  input  logic                re_MC,
  input  logic [31:0]         addr_MC,
  output logic [NUM_RT-1:0]   rdy_RT,
  output logic [127:0]        data_RT_out [NUM_RT],
  output logic                rdy_MC,
  output logic [127:0]        data_MC_out,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [127:0]        mem_wdata,
  input  logic [127:0]        mem_rdata
);

  localparam int IDX_W = $clog2(NUM_RT + 1);
  localparam int RT_W  = (NUM_RT > 1) ? $clog2(NUM_RT) : 1;
  localparam int CNT_W = $clog2(MEM_LAT + 1);
`ifdef MEM_ARB_MC_PRIO_EN
  localparam int RING = NUM_RT;
`else
  localparam int RING = NUM_RT + 1;
`endif
  localparam int RING_PAD = 1 << IDX_W;
  localparam logic [IDX_W-1:0] MC_IDX = IDX_W'(NUM_RT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [IDX_W-1:0]    grant_reg, grant_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                mem_en_reg, mem_en_next;
  logic                mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic [127:0]        mem_wdata_reg, mem_wdata_next;
  logic [127:0]        rdata_reg, rdata_next;
  logic [NUM_RT-1:0]   rdy_rt_reg, rdy_rt_next;
  logic                rdy_mc_reg, rdy_mc_next;

  logic [RING_PAD-1:0] req_ring;
  logic                win_valid;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W:0]      probe;
  logic [IDX_W:0]      ptr_inc;
  logic [RT_W-1:0]     rt_sel;
  logic                win_is_mc;

  // Unused upper ring slots stay zero so the probe index never needs a range check.
  always_comb begin
    req_ring = '0;
    req_ring[NUM_RT-1:0] = req_RT;
`ifndef MEM_ARB_MC_PRIO_EN
    req_ring[NUM_RT] = re_MC;
`endif
  end

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    probe     = '0;
`ifdef MEM_ARB_MC_PRIO_EN
    if (re_MC) begin
      win_valid = 1'b1;
      win_idx   = MC_IDX;
    end
`endif
    for (int i = 0; i < RING; i++) begin
      probe = {1'b0, rr_ptr_reg} + (IDX_W+1)'(i);
      if (probe >= (IDX_W+1)'(RING))
        probe = probe - (IDX_W+1)'(RING);
      if (!win_valid && req_ring[probe[IDX_W-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = probe[IDX_W-1:0];
      end
    end
  end

  assign win_is_mc = (win_idx == MC_IDX);
  assign rt_sel    = win_idx[RT_W-1:0];

  always_comb begin
    ptr_inc = {1'b0, win_idx} + (IDX_W+1)'(1);
    if (ptr_inc >= (IDX_W+1)'(RING))
      ptr_inc = '0;
  end

  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    grant_next     = grant_reg;
    cnt_next       = cnt_reg;
    mem_en_next    = 1'b0;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    rdata_next     = rdata_reg;
    rdy_rt_next    = '0;
    rdy_mc_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (win_valid) begin
          grant_next  = win_idx;
          mem_en_next = 1'b1;
          state_next  = ISSUE;
          if (win_is_mc) begin
            mem_we_next    = 1'b0;
            mem_addr_next  = addr_MC[ADDR_W+3:4];
            mem_wdata_next = '0;
`ifndef MEM_ARB_MC_PRIO_EN
            rr_ptr_next    = ptr_inc[IDX_W-1:0];
`endif
          end else begin
            mem_we_next    = we_RT[rt_sel];
            mem_addr_next  = addr_RT[rt_sel][ADDR_W+3:4];
            mem_wdata_next = data_RT_in[rt_sel];
            rr_ptr_next    = ptr_inc[IDX_W-1:0];
          end
        end
      end
      ISSUE: begin
        cnt_next   = CNT_W'(MEM_LAT - 1);
        state_next = WAIT;
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          if (!mem_we_reg)
            rdata_next = mem_rdata;
          // Completion pulse is registered here so it is visible during RESP.
          for (int i = 0; i < NUM_RT; i++)
            rdy_rt_next[i] = (grant_reg == IDX_W'(i));
          rdy_mc_next = (grant_reg == MC_IDX);
          state_next  = RESP;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      grant_reg     <= '0;
      cnt_reg       <= '0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      rdata_reg     <= '0;
      rdy_rt_reg    <= '0;
      rdy_mc_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      grant_reg     <= grant_next;
      cnt_reg       <= cnt_next;
      mem_en_reg    <= mem_en_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      rdata_reg     <= rdata_next;
      rdy_rt_reg    <= rdy_rt_next;
      rdy_mc_reg    <= rdy_mc_next;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_RT; gi++) begin : g_rt_out
      assign data_RT_out[gi] = rdata_reg;
    end
  endgenerate

  assign rdy_RT      = rdy_rt_reg;
  assign rdy_MC      = rdy_mc_reg;
  assign data_MC_out = rdata_reg;
  assign mem_en      = mem_en_reg;
  assign mem_we      = mem_we_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_wdata   = mem_wdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural fixed-latency memory (MEM_LAT=2).
// Expected MC/RT ordering follows MEM_ARB_MC_PRIO_EN when the same macro is given to the bench.
module tb_mem_arbiter;

  localparam int NUM_RT = 4;
  localparam int ADDR_W = 14;
  localparam int MEM_LAT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        req_RT;
  logic [3:0]        we_RT;
  logic [31:0]       addr_RT [NUM_RT];
  logic [127:0]      data_RT_in [NUM_RT];
  logic              re_MC;
  logic [31:0]       addr_MC;
  logic [3:0]        rdy_RT;
  logic [127:0]      data_RT_out [NUM_RT];
  logic              rdy_MC;
  logic [127:0]      data_MC_out;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [127:0]      mem_wdata;
  logic [127:0]      mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.NUM_RT(NUM_RT), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst), .req_RT(req_RT), .we_RT(we_RT), .addr_RT(addr_RT),
    .data_RT_in(data_RT_in), .re_MC(re_MC), .addr_MC(addr_MC), .rdy_RT(rdy_RT),
    .data_RT_out(data_RT_out), .rdy_MC(rdy_MC), .data_MC_out(data_MC_out),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory contents are a pure function of the word address; word 4 holds the A5 pattern.
  function automatic logic [127:0] rd_word(input logic [13:0] a);
    if (a == 14'd4)
      return {16{8'hA5}};
    return {8{2'b10, a}};
  endfunction

  logic         pipe_v0 = 1'b0, pipe_v1 = 1'b0;
  logic [127:0] pipe_d0 = '0, pipe_d1 = '0;
  always @(posedge clk) begin
    pipe_v0 <= mem_en & ~mem_we;
    pipe_d0 <= rd_word(mem_addr);
    pipe_v1 <= pipe_v0;
    pipe_d1 <= pipe_d0;
  end
  assign mem_rdata = pipe_v1 ? pipe_d1 : '0;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [3:0]   ord_rdy [5];
  logic [127:0] ord_dat [5];
  int           ord_cyc [5];
  int           ord_who [2];
  int           np;
  logic [3:0]   any_rdy;
  logic         saw3;

  initial begin
    rst = 1'b1; req_RT = '0; we_RT = '0; re_MC = 1'b0; addr_MC = '0;
    for (int i = 0; i < NUM_RT; i++) begin
      addr_RT[i] = '0;
      data_RT_in[i] = '0;
    end

    // Reset state
    step(3);
    chk("rst_rdy_rt", 128'(rdy_RT), 128'h0);
    chk("rst_rdy_mc", 128'(rdy_MC), 128'h0);
    chk("rst_mem_en", 128'(mem_en), 128'h0);
    chk("rst_mem_we", 128'(mem_we), 128'h0);
    chk("rst_mem_addr", 128'(mem_addr), 128'h0);
    chk("rst_mem_wdata", mem_wdata, 128'h0);
    chk("rst_rdata", data_MC_out, 128'h0);
    rst = 1'b0;
    step(1);

    // RT1 read of byte address 0x40
    addr_RT[1] = 32'h40; req_RT = 4'b0010;
    step(1);
    chk("a_mem_en", 128'(mem_en), 128'h1);
    chk("a_mem_we", 128'(mem_we), 128'h0);
    chk("a_mem_addr", 128'(mem_addr), 128'd4);
    step(1);
    chk("a_en_drop", 128'(mem_en), 128'h0);
    step(1);
    chk("a_rdy_early", 128'(rdy_RT), 128'h0);
    step(1);
    chk("a_rdy", 128'(rdy_RT), 128'b0010);
    chk("a_data_rt1", data_RT_out[1], {16{8'hA5}});
    chk("a_data_mc", data_MC_out, {16{8'hA5}});
    chk("a_rdy_mc", 128'(rdy_MC), 128'h0);
    req_RT = '0;
    step(1);
    chk("a_rdy_pulse", 128'(rdy_RT), 128'h0);

    // RT2 write of 0x1234 to byte address 0x100
    addr_RT[2] = 32'h100; data_RT_in[2] = 128'h1234; we_RT = 4'b0100; req_RT = 4'b0100;
    step(1);
    chk("b_mem_en", 128'(mem_en), 128'h1);
    chk("b_mem_we", 128'(mem_we), 128'h1);
    chk("b_mem_addr", 128'(mem_addr), 128'd16);
    chk("b_mem_wdata", mem_wdata, 128'h1234);
    step(2);
    chk("b_rdy_early", 128'(rdy_RT), 128'h0);
    step(1);
    chk("b_rdy", 128'(rdy_RT), 128'b0100);
    chk("b_rdata_kept", data_RT_out[2], {16{8'hA5}});
    req_RT = '0; we_RT = '0;
    step(1);

    // Reset during RT0's WAIT discards the access
    addr_RT[0] = 32'h70; req_RT = 4'b0001;
    step(1);
    chk("c_mem_addr", 128'(mem_addr), 128'd7);
    step(1);
    rst = 1'b1;
    step(1);
    chk("c_mem_en", 128'(mem_en), 128'h0);
    chk("c_rdy", 128'(rdy_RT), 128'h0);
    chk("c_rdata", data_RT_out[0], 128'h0);
    chk("c_mem_addr_rst", 128'(mem_addr), 128'h0);
    rst = 1'b0; req_RT = '0;
    any_rdy = '0;
    for (int c = 0; c < 6; c++) begin
      step(1);
      any_rdy = any_rdy | rdy_RT;
    end
    chk("c_no_rdy", 128'(any_rdy), 128'h0);

    // All four RTs requesting continuously from rr_ptr=0; RT3 address wraps to word 0xB
    addr_RT[0] = 32'h80; addr_RT[1] = 32'h90; addr_RT[2] = 32'hA0; addr_RT[3] = 32'hFFFC_00B0;
    for (int k = 0; k < 5; k++) begin
      ord_rdy[k] = '0; ord_dat[k] = '0; ord_cyc[k] = 0;
    end
    np = 0;
    req_RT = 4'b1111;
    for (int c = 1; c <= 30 && np < 5; c++) begin
      step(1);
      if (rdy_RT != 4'b0000) begin
        ord_rdy[np] = rdy_RT;
        ord_dat[np] = data_RT_out[3];
        ord_cyc[np] = c;
        np++;
        if (np == 5)
          req_RT = '0;
      end
    end
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("d_grant%0d", k), 128'(ord_rdy[k]), 128'(4'b0001 << (k % 4)));
      chk($sformatf("d_data%0d", k), ord_dat[k], rd_word(14'(8 + (k % 4))));
      if (k == 0)
        chk("d_first_cyc", 128'(ord_cyc[0]), 128'd4);
      else
        chk($sformatf("d_gap%0d", k), 128'(ord_cyc[k] - ord_cyc[k-1]), 128'd5);
    end
    step(6);

    // MC and RT0 contending in IDLE with rr_ptr=0
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    addr_MC = 32'h50; addr_RT[0] = 32'h60; re_MC = 1'b1; req_RT = 4'b0001;
    ord_who[0] = -1; ord_who[1] = -1; ord_dat[0] = '0; ord_dat[1] = '0;
    ord_cyc[0] = 0; ord_cyc[1] = 0;
    np = 0;
    for (int c = 1; c <= 20 && np < 2; c++) begin
      step(1);
      if (mem_en && mem_addr == 14'd5)
        chk("e_mc_we", 128'(mem_we), 128'h0);
      if (rdy_RT[0]) begin
        ord_who[np] = 0; ord_dat[np] = data_RT_out[0]; ord_cyc[np] = c; np++;
        req_RT = '0;
      end else if (rdy_MC) begin
        ord_who[np] = 4; ord_dat[np] = data_MC_out; ord_cyc[np] = c; np++;
        re_MC = 1'b0;
      end
    end
`ifdef MEM_ARB_MC_PRIO_EN
    chk("e_first", 128'(ord_who[0]), 128'd4);
    chk("e_second", 128'(ord_who[1]), 128'd0);
    chk("e_data_first", ord_dat[0], rd_word(14'd5));
    chk("e_data_second", ord_dat[1], rd_word(14'd6));
`else
    chk("e_first", 128'(ord_who[0]), 128'd0);
    chk("e_second", 128'(ord_who[1]), 128'd4);
    chk("e_data_first", ord_dat[0], rd_word(14'd6));
    chk("e_data_second", ord_dat[1], rd_word(14'd5));
`endif
    chk("e_gap", 128'(ord_cyc[1] - ord_cyc[0]), 128'd5);
    step(3);

    // RT3 drops during RT0's WAIT; RT0 re-requests a new address and is served next
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    addr_RT[0] = 32'hC0; addr_RT[3] = 32'hD0; req_RT = 4'b1001;
    step(2);
    req_RT = 4'b0001;
    saw3 = 1'b0;
    ord_rdy[0] = '0; ord_rdy[1] = '0; ord_dat[0] = '0; ord_dat[1] = '0;
    ord_cyc[0] = 0; ord_cyc[1] = 0;
    np = 0;
    for (int c = 1; c <= 20 && np < 2; c++) begin
      step(1);
      saw3 = saw3 | rdy_RT[3];
      if (rdy_RT != 4'b0000) begin
        ord_rdy[np] = rdy_RT; ord_dat[np] = data_RT_out[0]; ord_cyc[np] = c; np++;
        if (np == 1)
          addr_RT[0] = 32'hE0;
        else
          req_RT = '0;
      end
    end
    for (int c = 0; c < 6; c++) begin
      step(1);
      saw3 = saw3 | rdy_RT[3];
    end
    chk("f_first", 128'(ord_rdy[0]), 128'b0001);
    chk("f_data_first", ord_dat[0], rd_word(14'hC));
    chk("f_second", 128'(ord_rdy[1]), 128'b0001);
    chk("f_data_second", ord_dat[1], rd_word(14'hE));
    chk("f_gap", 128'(ord_cyc[1] - ord_cyc[0]), 128'd5);
    chk("f_rt3_unserved", 128'(saw3), 128'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the shared 128-bit main-memory bank between NUM_RT ray-tracer cores and the memory controller (MC).
- Performs one access at a time: arbitrate, issue to memory, wait a fixed read latency, return data and pulse the owner's ready.
- RT cores are served round-robin. MC placement in arbitration depends on MEM_ARB_MC_PRIO_EN.

Parameters:
- NUM_RT, 4, number of ray-tracer requesters.
- ADDR_W, 14, memory word-address width (128-bit words).
- MEM_LAT, 2, memory read latency in cycles from mem_en to mem_rdata valid (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_RT  in  [NUM_RT]  RT access request, held until that RT's rdy.
- we_RT  in  [NUM_RT]  1=write, 0=read; valid while req_RT is high.
- addr_RT  in  [NUM_RT]x32  byte address; bits [ADDR_W+3:4] are used.
- data_RT_in  in  [NUM_RT]x128  write data.
- re_MC  in  1  MC read request, held until rdy_MC.
- addr_MC  in  32  MC byte address.
- rdy_RT  out  [NUM_RT]  one-cycle completion pulse per RT.
- data_RT_out  out  [NUM_RT]x128  read data; all RT ports carry the same rdata register.
- rdy_MC  out  1  one-cycle MC completion pulse.
- data_MC_out  out  128  read data (same register).
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  128  memory write data.
- mem_rdata  in  128  memory read data.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, rdata=0, all rdy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0. Any in-flight access is discarded with no rdy.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE: if any request is high, register the grant index and the winner's we/addr/wdata, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE: hold for exactly 1 cycle with mem_en=1 and mem_we/mem_addr/mem_wdata from the grant. Load wait counter with MEM_LAT-1.
- WAIT: decrement the counter. When it reaches 0, capture mem_rdata into rdata (reads only; writes leave rdata unchanged), then go to RESP.
- RESP: rdy of the granted requester is 1 for this cycle only. Then return to IDLE.
- Timing: request seen in IDLE at cycle t gives mem_en at t+1 and rdy at t+2+MEM_LAT. Throughput is one access per MEM_LAT+3 cycles.
- Requester rule: deassert or replace req on the edge after rdy. The arbiter never samples requests in RESP, so a stale request is never re-granted.
- RT round-robin: search indices rr_ptr, rr_ptr+1, ... modulo NUM_RT; lowest such index with req wins. On an RT grant g, rr_ptr <= (g+1) mod NUM_RT. rr_ptr is unchanged on an MC grant.
- MC issues reads only: mem_we=0 on MC grants.
- Requests arriving or dropping during ISSUE/WAIT/RESP do not affect the current access.
- A request dropped before grant is simply not served. Dropping after grant is a protocol violation; the access still completes and rdy still pulses.
- Address wrap: addresses beyond 2^ADDR_W words alias via truncation.
- Outputs are registered; no combinational path from request inputs to mem_* or rdy.

Optional Feature:
- Macro: MEM_ARB_MC_PRIO_EN.
- Defined: MC has strict priority. If re_MC is high in IDLE, MC wins over all RT requests.
- Undefined: MC is slot NUM_RT in the round-robin ring (ring size NUM_RT+1). rr_ptr covers 0..NUM_RT and advances past MC grants too.

Test Plan:
- Reset mid-WAIT during an RT0 read: assert rst -> next cycle state IDLE, no rdy_RT[0], mem_en=0, rdata=0.
- Single RT1 read of addr 0x40, MEM_LAT=2, mem returns 0xA5..A5 -> mem_addr=4 at t+1, rdy_RT[1] at t+4, data_RT_out[1]=0xA5..A5.
- RT2 write of 0x1234 to addr 0x100 -> mem_en=1, mem_we=1, mem_addr=16, mem_wdata=0x1234; rdy_RT[2] at t+4; rdata unchanged.
- All four RT requesting continuously from reset -> grant order 0,1,2,3,0; rdy pulses spaced 5 cycles apart.
- re_MC and req_RT[0] both high in IDLE with macro defined -> MC served first, then RT0. Without macro and rr_ptr=0 -> RT0 first, then MC.
- req_RT[3] dropped during RT0's WAIT -> RT3 not served; next grant goes to the next requester still holding req.
